// File: rtl/nand_delay_line.sv
// Clocked delay line replacing gate-level inverter chains: DEPTH register stages,
// run-time tap, optional per-stage inversion, fill-based valid flag and edge detect.
module nand_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 6,
  parameter int TW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  input  logic [TW-1:0]    tap,
  input  logic             inv_mode,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             dout_edge
);

  localparam logic [TW-1:0] DEPTH_T = TW'(DEPTH);

  logic [WIDTH-1:0] stg [DEPTH];
  logic [TW-1:0]    cnt;
  logic [TW-1:0]    tap_eff;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] dout_q;
  logic             valid_q;

  always_comb begin
    tap_eff = tap;
    if (tap == '0) begin
      tap_eff = TW'(1);
    end else if (tap > DEPTH_T) begin
      tap_eff = DEPTH_T;
    end
  end

  // Compare-based mux keeps the select width independent of the array depth.
  always_comb begin
    raw = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (tap_eff == TW'(k + 1)) begin
        raw = stg[k];
      end
    end
  end

  assign dout_valid = (cnt >= tap_eff);

  // An odd number of inverting stages flips polarity; an even number cancels out.
  always_comb begin
    dout = '0;
    if (dout_valid) begin
      dout = (inv_mode && tap_eff[0]) ? ~raw : raw;
    end
  end

  assign dout_edge = dout_valid & valid_q & (dout != dout_q);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        stg[k] <= '0;
      end
      cnt     <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout;
      valid_q <= dout_valid;
      if (en) begin
        stg[0] <= din;
        for (int k = 1; k < DEPTH; k++) begin
          stg[k] <= stg[k-1];
        end
        if (cnt != DEPTH_T) begin
          cnt <= cnt + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_nand_delay_line.sv
// Directed bench for nand_delay_line: a 1-bit and an 8-bit instance share controls;
// a sample queue predicts dout for each enabled edge.
module tb_nand_delay_line;

  localparam int DEPTH = 6;
  localparam int TW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst, en, flush, inv_mode;
  logic [TW-1:0] tap;
  logic          din1;
  logic [7:0]    din8;
  logic          dout1, valid1, edge1;
  logic [7:0]    dout8;
  logic          valid8, edge8;

  nand_delay_line #(.WIDTH(1), .DEPTH(DEPTH)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .din(din1), .tap(tap),
    .inv_mode(inv_mode), .dout(dout1), .dout_valid(valid1), .dout_edge(edge1)
  );

  nand_delay_line #(.WIDTH(8), .DEPTH(DEPTH)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .din(din8), .tap(tap),
    .inv_mode(inv_mode), .dout(dout8), .dout_valid(valid8), .dout_edge(edge8)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  logic       sel8     = 1'b0;
  int         tap_t    = 1;
  logic [7:0] last_exp = '0;
  logic       has_last = 1'b0;
  int         edge_cnt = 0;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] cur_dout();
    return sel8 ? dout8 : {7'b0, dout1};
  endfunction

  function automatic logic [7:0] cur_valid();
    return sel8 ? {7'b0, valid8} : {7'b0, valid1};
  endfunction

  // Drive one cycle; an enabled edge pushes its expected output, which is popped
  // once tap_t samples are in flight.
  task automatic sb_step(input logic e, input logic [7:0] d);
    logic [7:0] v;
    en   = e;
    din8 = d;
    din1 = d[0];
    tick();
    v = d ^ ((inv_mode && (tap_t % 2 == 1)) ? 8'hFF : 8'h00);
    if (!sel8) v = v & 8'h01;
    if (e) exp_q.push_back(v);
    edge_cnt += sel8 ? int'(edge8) : int'(edge1);
    if (exp_q.size() == tap_t) begin
      last_exp = exp_q.pop_front();
      has_last = 1'b1;
      chk("sb_valid", cur_valid(), 8'h01);
      chk("sb_dout", cur_dout(), last_exp);
    end else if (has_last) begin
      chk("hold_valid", cur_valid(), 8'h01);
      chk("hold_dout", cur_dout(), last_exp);
    end else begin
      chk("fill_valid", cur_valid(), 8'h00);
      chk("fill_dout", cur_dout(), 8'h00);
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    en    = 1'b1;
    din8  = 8'hEE;
    din1  = 1'b1;
    tick();
    flush = 1'b0;
    en    = 1'b0;
    exp_q.delete();
    has_last = 1'b0;
    chk("flush_valid", cur_valid(), 8'h00);
    chk("flush_dout", cur_dout(), 8'h00);
    chk("flush_edge", sel8 ? {7'b0, edge8} : {7'b0, edge1}, 8'h00);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; inv_mode = 1'b0;
    tap = TW'(6); din1 = 1'b0; din8 = '0;
    tick();
    tick();
    chk("rst_dout1", {7'b0, dout1}, 8'h00);
    chk("rst_valid1", {7'b0, valid1}, 8'h00);
    chk("rst_edge1", {7'b0, edge1}, 8'h00);
    chk("rst_dout8", dout8, 8'h00);
    chk("rst_valid8", {7'b0, valid8}, 8'h00);
    chk("rst_edge8", {7'b0, edge8}, 8'h00);
    rst = 1'b0;

    // 1-bit buffer chain, tap 6, din steps 0->1 at cycle 10
    sel8 = 1'b0; tap = TW'(6); tap_t = 6; inv_mode = 1'b0; edge_cnt = 0;
    for (int i = 0; i < 20; i++) sb_step(1'b1, (i >= 10) ? 8'h01 : 8'h00);
    chk("t1_edges", 8'(edge_cnt), 8'h01);

    // Inverting chain, tap 5, then tap 6 restores polarity
    do_flush();
    inv_mode = 1'b1; tap = TW'(5); tap_t = 5; edge_cnt = 0;
    for (int i = 0; i < 20; i++) sb_step(1'b1, (i >= 10) ? 8'h01 : 8'h00);
    chk("t2_edges", 8'(edge_cnt), 8'h01);
    tap = TW'(6);
    #1;
    chk("t2_tap6_dout", {7'b0, dout1}, 8'h01);
    chk("t2_tap6_valid", {7'b0, valid1}, 8'h01);

    // 8-bit, gapped enable, tap 2
    sel8 = 1'b1; inv_mode = 1'b0; tap = TW'(2); tap_t = 2;
    do_flush();
    sb_step(1'b1, 8'hA5);
    sb_step(1'b0, 8'h3C);
    sb_step(1'b1, 8'h3C);
    sb_step(1'b0, 8'hFF);
    sb_step(1'b1, 8'h00);

    // Full line, tap lengthened 2->6 mid-stream
    do_flush();
    for (int i = 0; i < 8; i++) sb_step(1'b1, 8'h10 + 8'(i));
    tap = TW'(6);
    #1;
    chk("t4_tap6_dout", dout8, 8'h12);
    chk("t4_tap6_valid", {7'b0, valid8}, 8'h01);
    do_flush();
    tap_t = 6;
    for (int i = 0; i < 3; i++) sb_step(1'b1, 8'($urandom_range(0, 255)));

    // Tap clamps and flush priority over en
    tap = TW'(0); tap_t = 1;
    do_flush();
    sb_step(1'b0, 8'h55);
    for (int i = 0; i < 4; i++) sb_step(1'b1, 8'($urandom_range(0, 255)));
    tap = TW'(7); tap_t = 6;
    do_flush();
    for (int i = 0; i < 8; i++) sb_step(1'b1, 8'($urandom_range(0, 255)));
    sb_step(1'b0, 8'($urandom_range(0, 255)));

    // rst + flush + en together
    rst = 1'b1; flush = 1'b1; en = 1'b1; din8 = 8'h77;
    tick();
    chk("t5_rst_dout", dout8, 8'h00);
    chk("t5_rst_valid", {7'b0, valid8}, 8'h00);
    chk("t5_rst_edge", {7'b0, edge8}, 8'h00);
    rst = 1'b0; flush = 1'b0;
    exp_q.delete(); has_last = 1'b0;
    tap = TW'(1); tap_t = 1;
    sb_step(1'b0, 8'h00);
    sb_step(1'b1, 8'h77);

    // Mid-stream reset with inverting odd tap
    inv_mode = 1'b1; tap = TW'(3); tap_t = 3;
    do_flush();
    for (int i = 0; i < 6; i++) sb_step(1'b1, 8'($urandom_range(0, 255)));
    rst = 1'b1; en = 1'b1;
    tick();
    chk("t6_dout8", dout8, 8'h00);
    chk("t6_valid8", {7'b0, valid8}, 8'h00);
    chk("t6_edge8", {7'b0, edge8}, 8'h00);
    chk("t6_dout1", {7'b0, dout1}, 8'h00);
    chk("t6_valid1", {7'b0, valid1}, 8'h00);
    rst = 1'b0; en = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
